// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB TX scheduler.
// Contents: scheduler state enum, protocol timing constants, timer and FIFO count widths.
package usb_tx_pkg;

  localparam int PKT_BYTES       = 64;
  localparam int TURNAROUND_CYC  = 16;
  localparam int ACK_TIMEOUT_CYC = 1024;
  localparam int MAX_RETRY       = 3;

  localparam int TIMER_W    = $clog2(ACK_TIMEOUT_CYC);
  localparam int FIFO_CNT_W = 7;
  localparam int RETRY_W    = 2;

  localparam logic [TIMER_W-1:0]    TURN_LOAD   = TIMER_W'(TURNAROUND_CYC - 1);
  localparam logic [TIMER_W-1:0]    ACK_LOAD    = TIMER_W'(ACK_TIMEOUT_CYC - 1);
  localparam logic [FIFO_CNT_W-1:0] PKT_THRESH  = FIFO_CNT_W'(PKT_BYTES);
  localparam logic [RETRY_W-1:0]    RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    TURNAROUND = 3'd1,
    ISSUE      = 3'd2,
    WAIT_START = 3'd3,
    WAIT_END   = 3'd4,
    WAIT_ACK   = 3'd5
  } tx_sched_state_t;

endpackage

// File: rtl/tx_sched_timer.sv
// Loadable down-counter with zero flag. Counting stops at zero (no wrap).
// Ports:
//   clk, n_rst   clock, async active-low reset
//   load_i       load load_val_i (takes priority over en_i)
//   load_val_i   value to load
//   en_i         decrement enable
//   zero_o       count is zero
module tx_sched_timer
  import usb_tx_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               en_i,
  output logic               zero_o
);

  logic [TIMER_W-1:0] count_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/tx_scheduler.sv
// USB TX scheduler: on an IN token waits bus turnaround, then asks the txpu for a
// DATA packet (FIFO holds a full packet) or a NAK. After DATA it waits for the host
// ACK, committing the packet on ACK or rewinding the FIFO on timeout, dropping the
// packet and flagging tx_error after too many consecutive timeouts.
// Optional feature: define TX_SCHED_STATS_EN to get saturating statistics counters;
// otherwise the stat_* ports read zero.
// Ports:
//   clk, n_rst                        clock, async active-low reset
//   in_token, ack_rcvd                1-cycle pulses from RXPU
//   fifo_count                        bytes held in TX FIFO
//   is_txing                          txpu busy
//   clear_error                       clears sticky tx_error
//   send_data, send_nak               1-cycle requests to txpu
//   fifo_commit, fifo_rewind          1-cycle FIFO controls
//   await_ack                         high while waiting for handshake
//   tx_error                          sticky error
//   stat_data_cnt/nak_cnt/retry_cnt   statistics
//
// state      | meaning
// IDLE       | waiting for IN token
// TURNAROUND | bus turnaround timer running, also waits for txpu idle
// ISSUE      | latch data/NAK decision, arm start guard
// WAIT_START | waiting for txpu to go busy (guarded)
// WAIT_END   | txpu sending
// WAIT_ACK   | data sent, waiting for host ACK (timed)
module tx_scheduler
  import usb_tx_pkg::*;
(
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  in_token,
  input  logic                  ack_rcvd,
  input  logic [FIFO_CNT_W-1:0] fifo_count,
  input  logic                  is_txing,
  input  logic                  clear_error,
  output logic                  send_data,
  output logic                  send_nak,
  output logic                  fifo_commit,
  output logic                  fifo_rewind,
  output logic                  await_ack,
  output logic                  tx_error,
  output logic [15:0]           stat_data_cnt,
  output logic [15:0]           stat_nak_cnt,
  output logic [15:0]           stat_retry_cnt
);

  tx_sched_state_t    state_q;
  logic               is_data_q;
  logic               fire_q;
  logic [RETRY_W-1:0] retry_q;
  logic               send_data_q, send_nak_q, fifo_commit_q, fifo_rewind_q;
  logic               await_ack_q, tx_error_q, tx_error_d;

  logic               tmr_load, tmr_en, tmr_zero;
  logic [TIMER_W-1:0] tmr_val;
  logic               ack_hit, ack_to, drop, guard_err;

  // An IN token while waiting for ACK means the host gave up: same as a timeout.
  assign ack_hit   = (state_q == WAIT_ACK) && ack_rcvd;
  assign ack_to    = (state_q == WAIT_ACK) && !ack_rcvd && (in_token || tmr_zero);
  assign drop      = ack_to && (retry_q == RETRY_LIMIT);
  assign guard_err = (state_q == WAIT_START) && !is_txing && tmr_zero;

  // A new error event beats a simultaneous clear.
  assign tx_error_d = guard_err || drop || (tx_error_q && !clear_error);

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_load = in_token;
        tmr_val  = TURN_LOAD;
      end
      TURNAROUND: tmr_en = 1'b1;
      ISSUE: begin
        tmr_load = 1'b1;
        tmr_val  = ACK_LOAD;
      end
      WAIT_START: tmr_en = 1'b1;
      WAIT_END: begin
        tmr_load = !is_txing && is_data_q;
        tmr_val  = ACK_LOAD;
      end
      WAIT_ACK: begin
        if (!ack_rcvd) begin
          if (in_token) begin
            tmr_load = 1'b1;
            tmr_val  = TURN_LOAD;
          end else begin
            tmr_en = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  tx_sched_timer u_timer (
    .clk        (clk),
    .n_rst      (n_rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      is_data_q     <= 1'b0;
      fire_q        <= 1'b0;
      retry_q       <= '0;
      send_data_q   <= 1'b0;
      send_nak_q    <= 1'b0;
      fifo_commit_q <= 1'b0;
      fifo_rewind_q <= 1'b0;
      await_ack_q   <= 1'b0;
      tx_error_q    <= 1'b0;
    end else begin
      // Decision latched in ISSUE becomes the send pulse one cycle later.
      send_data_q   <= fire_q && is_data_q;
      send_nak_q    <= fire_q && !is_data_q;
      fire_q        <= 1'b0;
      fifo_commit_q <= 1'b0;
      fifo_rewind_q <= 1'b0;
      await_ack_q   <= 1'b0;
      tx_error_q    <= tx_error_d;
      case (state_q)
        IDLE: if (in_token) state_q <= TURNAROUND;
        TURNAROUND: if (tmr_zero && !is_txing) state_q <= ISSUE;
        ISSUE: begin
          is_data_q <= (fifo_count >= PKT_THRESH);
          fire_q    <= 1'b1;
          state_q   <= WAIT_START;
        end
        WAIT_START: begin
          if (is_txing) begin
            state_q <= WAIT_END;
          end else if (tmr_zero) begin
            fifo_rewind_q <= is_data_q;
            state_q       <= IDLE;
          end
        end
        WAIT_END: begin
          if (!is_txing) begin
            if (is_data_q) begin
              await_ack_q <= 1'b1;
              state_q     <= WAIT_ACK;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        WAIT_ACK: begin
          if (ack_hit) begin
            fifo_commit_q <= 1'b1;
            retry_q       <= '0;
            state_q       <= IDLE;
          end else if (ack_to) begin
            if (drop) begin
              fifo_commit_q <= 1'b1;
              retry_q       <= '0;
            end else begin
              fifo_rewind_q <= 1'b1;
              retry_q       <= retry_q + 1'b1;
            end
            state_q <= in_token ? TURNAROUND : IDLE;
          end else begin
            await_ack_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign send_data   = send_data_q;
  assign send_nak    = send_nak_q;
  assign fifo_commit = fifo_commit_q;
  assign fifo_rewind = fifo_rewind_q;
  assign await_ack   = await_ack_q;
  assign tx_error    = tx_error_q;

`ifdef TX_SCHED_STATS_EN
  logic [15:0] data_cnt_q, nak_cnt_q, retry_cnt_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_cnt_q  <= '0;
      nak_cnt_q   <= '0;
      retry_cnt_q <= '0;
    end else begin
      if (ack_hit && (data_cnt_q != 16'hFFFF))    data_cnt_q  <= data_cnt_q + 1'b1;
      if (send_nak_q && (nak_cnt_q != 16'hFFFF))  nak_cnt_q   <= nak_cnt_q + 1'b1;
      if (ack_to && (retry_cnt_q != 16'hFFFF))    retry_cnt_q <= retry_cnt_q + 1'b1;
    end
  end

  assign stat_data_cnt  = data_cnt_q;
  assign stat_nak_cnt   = nak_cnt_q;
  assign stat_retry_cnt = retry_cnt_q;
`else
  assign stat_data_cnt  = '0;
  assign stat_nak_cnt   = '0;
  assign stat_retry_cnt = '0;
`endif

endmodule
